// File: rtl/eqn_pipe.sv
// eqn_pipe: elastic 3-stage pipeline computing E = (A + B) * C + A (unsigned, lossless).
// Latency: 3 cycles from the acceptance cycle to out_valid; 1 result/cycle sustained.
// Backpressure: valid/ready on both sides; stall freezes every stage and forces in_ready=0.
//
// Ports:
//   clk, rst (sync, active-high), flush (drop in-flight ops), stall (freeze)
//   in_valid/in_ready + A, B, C          operand side
//   out_valid/out_ready + E              result side
//   s1, s2, stage_valid                  debug view of the stage registers
//   res_count                            completed output handshakes, wraps
//
// Optional feature macro: EQN_PIPE_COLLAPSE_EN
//   defined   -> per-stage ready chain, bubbles are squeezed out
//   undefined -> one global enable, the whole pipe freezes on a blocked output
module eqn_pipe #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2*WIDTH+1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   E,
  output logic [WIDTH:0]     s1,
  output logic [2*WIDTH:0]   s2,
  output logic [2:0]         stage_valid,
  output logic [CNT_W-1:0]   res_count
);

  localparam int S1_W = WIDTH + 1;
  localparam int S2_W = 2*WIDTH + 1;

  // Stage valid bits
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;

  // Stage data registers
  logic [S1_W-1:0]  s1_q, s1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] c1_q, c1_d;
  logic [S2_W-1:0]  s2_q, s2_d;
  logic [WIDTH-1:0] a2_q, a2_d;
  logic [OUT_W-1:0] e_q,  e_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-stage load enables
  logic en1, en2, en3;
  logic out_xfer;

`ifdef EQN_PIPE_COLLAPSE_EN
  // Ready ripples back from the output: a stage may load whenever it is
  // empty or its occupant is moving on, so bubbles get filled.
  always_comb begin
    en3 = !stall && (!v3_q || out_ready);
    en2 = !stall && (!v2_q || en3);
    en1 = !stall && (!v1_q || en2);
  end
`else
  // Single enable: everything moves together or nothing moves.
  logic en_g;
  assign en_g = !stall && (!v3_q || out_ready);
  always_comb begin
    en3 = en_g;
    en2 = en_g;
    en1 = en_g;
  end
`endif

  assign in_ready = en1;
  assign out_xfer = v3_q && out_ready;

  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    s1_d  = s1_q;
    a1_d  = a1_q;
    c1_d  = c1_q;
    s2_d  = s2_q;
    a2_d  = a2_q;
    e_d   = e_q;
    // Output handshakes count even in a flush or stall cycle.
    cnt_d = cnt_q + CNT_W'(out_xfer);

    if (flush) begin
      // Only validity is dropped; data registers keep their contents.
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else begin
      if (en1) begin
        v1_d = in_valid;
        s1_d = S1_W'(A) + S1_W'(B);
        a1_d = A;
        c1_d = C;
      end
      if (en2) begin
        v2_d = v1_q;
        // (WIDTH+1) x WIDTH bits fits exactly in 2*WIDTH+1 bits.
        s2_d = S2_W'(s1_q) * S2_W'(c1_q);
        a2_d = a1_q;
      end
      if (en3) begin
        v3_d = v2_q;
        e_d  = OUT_W'(s2_q) + OUT_W'(a2_q);
      end else if (out_xfer) begin
        // Only reachable under stall: the consumer took the result, so the
        // last stage empties while everything else stays frozen.
        v3_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= '0;
      a1_q  <= '0;
      c1_q  <= '0;
      s2_q  <= '0;
      a2_q  <= '0;
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      s1_q  <= s1_d;
      a1_q  <= a1_d;
      c1_q  <= c1_d;
      s2_q  <= s2_d;
      a2_q  <= a2_d;
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = v3_q;
  assign E           = e_q;
  assign s1          = s1_q;
  assign s2          = s2_q;
  assign stage_valid = {v3_q, v2_q, v1_q};
  assign res_count   = cnt_q;

endmodule
